// File: rtl/m10k_row_reader_pkg.sv
// m10k_pkg: shared state encoding and sizing helpers for the m10k port-B row reader.
package m10k_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_e;

    function automatic int calc_aw(input int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction

    function automatic int row_w(input int n_banks, input int w);
        return n_banks * w;
    endfunction

    function automatic bit fifo_depth_ok(input int fifo_depth, input int read_latency);
        return fifo_depth >= read_latency + 1;
    endfunction
endpackage

// File: rtl/m10k_row_reader_if.sv
// m10k_row_reader_if: bank port-B read bus plus the row output stream.
interface m10k_row_reader_if #(
    parameter int N_BANKS = 4,
    parameter int W       = 32,
    parameter int AW      = 4
);
    logic [N_BANKS-1:0]         b_en;
    logic [N_BANKS-1:0][AW-1:0] b_addr;
    logic [N_BANKS-1:0][W-1:0]  b_dout;
    logic                       m_valid;
    logic                       m_ready;
    logic [N_BANKS*W-1:0]       m_data;
    logic                       m_last;

    modport master (output b_en, b_addr, m_valid, m_data, m_last, input b_dout, m_ready);
    modport slave  (input b_en, b_addr, m_valid, m_data, m_last, output b_dout, m_ready);
endinterface

// File: rtl/m10k_row_reader_fifo.sv
// sync_fifo: show-ahead synchronous FIFO with occupancy count; push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && cnt_q != '0;
    assign do_push = push_i && (cnt_q != CW'(DEPTH) || do_pop);
    assign dout_o  = mem_q[rd_q];
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/m10k_row_reader.sv
// m10k_row_reader: credit-limited lockstep reads of consecutive bank rows, latency absorbed by a row FIFO.
module m10k_row_reader
    import m10k_pkg::*;
#(
    parameter int N_BANKS        = 4,
    parameter int W              = 32,
    parameter int DEPTH_PER_BANK = 16,
    parameter int READ_LATENCY   = 3,
    parameter int FIFO_DEPTH     = 4,
    localparam int AW = calc_aw(DEPTH_PER_BANK),
    localparam int RW = row_w(N_BANKS, W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    m10k_row_reader_if.master bus
);
    localparam int            CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [1:0]    S_IDLE  = IDLE;
    localparam logic [1:0]    S_ISSUE = ISSUE;
    localparam logic [1:0]    S_DRAIN = DRAIN;
    localparam logic [AW:0]   DMAX    = (AW + 1)'(DEPTH_PER_BANK);

    if (!fifo_depth_ok(FIFO_DEPTH, READ_LATENCY)) begin : g_bad_depth
        $error("FIFO_DEPTH must be at least READ_LATENCY+1");
    end

    logic [1:0]              state_q, state_d;
    logic [AW-1:0]           base_q, base_d;
    logic [AW:0]             len_q, len_d, issued_q, issued_d, len_c, addr_sum;
    logic                    done_q, done_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d, lst_q, lst_d;
    logic                    issue, pop, credit, last_issue;
    logic [AW-1:0]           rd_addr;
    logic [CW-1:0]           fifo_cnt;
    logic                    fifo_empty;
    logic [RW:0]             fifo_dout;

    assign len_c = len > DMAX ? DMAX : len;

    always_comb begin
        pop        = bus.m_valid & bus.m_ready;
        // Rows already buffered plus rows still in the bank pipe must fit, counting the slot freed this cycle.
        credit     = int'(fifo_cnt) + $countones(vld_q) - int'(pop) < FIFO_DEPTH;
        issue      = state_q == S_ISSUE && credit;
        last_issue = issued_q + 1'b1 == len_q;
        addr_sum   = {1'b0, base_q} + issued_q;
        rd_addr    = AW'(addr_sum >= DMAX ? addr_sum - DMAX : addr_sum);
        vld_d      = (vld_q << 1) | READ_LATENCY'(issue);
        lst_d      = (lst_q << 1) | READ_LATENCY'(issue & last_issue);
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        issued_d   = issued_q;
        done_d     = 1'b0;
        if (state_q == S_IDLE && start) begin
            base_d   = base_addr;
            len_d    = len_c;
            issued_d = '0;
            state_d  = len_c == '0 ? S_IDLE : S_ISSUE;
            done_d   = len_c == '0;
        end
        if (issue) begin
            issued_d = issued_q + 1'b1;
            state_d  = last_issue ? S_DRAIN : state_q;
        end
        // Accepting the flagged row empties the FIFO and the pipe by construction.
        if (state_q == S_DRAIN && pop && bus.m_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            done_q   <= 1'b0;
            vld_q    <= '0;
            lst_q    <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            done_q   <= done_d;
            vld_q    <= vld_d;
            lst_q    <= lst_d;
        end
    end

    sync_fifo #(.WIDTH(RW + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (vld_q[READ_LATENCY-1]),
        .din_i  ({bus.b_dout, lst_q[READ_LATENCY-1]}),
        .pop_i  (pop),
        .dout_o (fifo_dout),
        .empty_o(fifo_empty),
        .count_o(fifo_cnt)
    );

    assign bus.b_en    = {N_BANKS{issue}};
    assign bus.b_addr  = {N_BANKS{issue ? rd_addr : AW'(0)}};
    assign bus.m_valid = !fifo_empty;
    assign bus.m_data  = fifo_dout[RW:1];
    assign bus.m_last  = !fifo_empty && fifo_dout[0];
    assign busy        = state_q != S_IDLE;
    assign done        = done_q;
endmodule

// File: tb/tb_m10k_row_reader.sv
// tb_m10k_row_reader: directed bench with a latency-3 bank model and a negedge stream monitor.
module tb_m10k_row_reader;
    localparam int NB = 4, W = 32, D = 16, AW = 4, RL = 3, FD = 4, RW = NB * W;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy, done;

    m10k_row_reader_if #(.N_BANKS(NB), .W(W), .AW(AW)) bus ();

    m10k_row_reader #(
        .N_BANKS(NB), .W(W), .DEPTH_PER_BANK(D), .READ_LATENCY(RL), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NB-1:0][AW-1:0] apipe [RL];
    always @(posedge clk) begin
        apipe[0] <= bus.b_addr;
        for (int i = 1; i < RL; i++) apipe[i] <= apipe[i-1];
    end
    always_comb
        for (int k = 0; k < NB; k++) bus.b_dout[k] = {8'(k), 8'(apipe[RL-1][k]), 16'hA55A};

    function automatic logic [RW-1:0] exp_row(input int a);
        logic [RW-1:0] r;
        for (int k = 0; k < NB; k++) r[k*W +: W] = {8'(k), 8'(a), 16'hA55A};
        return r;
    endfunction

    logic [RW-1:0] got_d [$];
    logic          got_l [$];
    int            got_c [$];
    int            done_c [$];
    int            n_en = 0, n_pop = 0, max_out = 0, stall_err = 0, en_err = 0;
    logic          pv_stall = 1'b0, pv_last;
    logic [RW-1:0] pv_data;

    always @(negedge clk) begin
        if (bus.b_en != '0) n_en++;
        if (bus.b_en != '0 && bus.b_en != '1) en_err++;
        if (bus.m_valid && bus.m_ready) begin
            got_d.push_back(bus.m_data);
            got_l.push_back(bus.m_last);
            got_c.push_back(cyc);
            n_pop++;
        end
        if (done) done_c.push_back(cyc);
        if (pv_stall && (!bus.m_valid || bus.m_data !== pv_data || bus.m_last !== pv_last)) stall_err++;
        pv_stall = bus.m_valid && !bus.m_ready;
        pv_data  = bus.m_data;
        pv_last  = bus.m_last;
        if (n_en - n_pop > max_out) max_out = n_en - n_pop;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr();
        got_d.delete(); got_l.delete(); got_c.delete(); done_c.delete();
        n_en = 0; n_pop = 0; max_out = 0; stall_err = 0; en_err = 0;
    endtask

    task automatic xfer(input int b, input int l, input bit toggle, input bit restart, output int c0);
        clr();
        base_addr = AW'(b);
        len = (AW + 1)'(l);
        start = 1'b1;
        bus.m_ready = 1'b1;
        c0 = cyc;
        step();
        for (int i = 1; i < 200 && done_c.size() == 0; i++) begin
            bus.m_ready = !toggle || i % 4 == 0 || i % 4 == 3;
            start = restart && i == 3;
            if (start) begin
                base_addr = 4'd9;
                len = 5'd2;
            end
            step();
        end
        start = 1'b0;
        bus.m_ready = 1'b1;
        step(3);
        chk("done_count", done_c.size(), 1);
        chk("busy_after", busy, 0);
    endtask

    task automatic chk_rows(input string tag, input int b, input int l);
        chk({tag, "_nrows"}, got_d.size(), l);
        for (int r = 0; r < l && r < got_d.size(); r++) begin
            chk($sformatf("%s_data%0d", tag, r), got_d[r], exp_row((b + r) % D));
            chk($sformatf("%s_last%0d", tag, r), got_l[r], r == l - 1);
        end
    endtask

    int c0;

    initial begin
        bus.m_ready = 1'b1;
        step(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_b_en", bus.b_en, 0);
        chk("rst_b_addr", bus.b_addr, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_last", bus.m_last, 0);
        rst = 1'b0;
        step(2);

        xfer(0, 16, 0, 0, c0);
        chk_rows("full", 0, 16);
        chk("full_first_cyc", got_c.size() > 0 ? got_c[0] - c0 : -1, 5);
        chk("full_last_cyc", got_c.size() > 15 ? got_c[15] - c0 : -1, 20);
        chk("full_done_cyc", done_c.size() > 0 ? done_c[0] - c0 : -1, 21);
        chk("full_en_count", n_en, 16);
        chk("full_en_bits", en_err, 0);

        xfer(14, 4, 0, 0, c0);
        chk_rows("wrap", 14, 4);

        xfer(2, 8, 1, 0, c0);
        chk_rows("bp", 2, 8);
        chk("bp_outstanding", max_out <= FD, 1);
        chk("bp_stable", stall_err, 0);

        xfer(0, 0, 0, 0, c0);
        chk("zero_done_cyc", done_c.size() > 0 ? done_c[0] - c0 : -1, 1);
        chk("zero_en", n_en, 0);
        chk("zero_rows", got_d.size(), 0);

        xfer(5, 20, 0, 0, c0);
        chk_rows("clamp", 5, 16);

        clr();
        bus.m_ready = 1'b0;
        base_addr = '0;
        len = 5'd16;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 50 && n_en < 3; i++) step();
        chk("mid_issued", n_en, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_m_valid", bus.m_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        step(3);
        chk("mid_no_done", done_c.size(), 0);
        xfer(3, 2, 0, 0, c0);
        chk_rows("after_rst", 3, 2);

        xfer(0, 6, 0, 1, c0);
        chk_rows("restart", 0, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
